// File: rtl/sargantana_icache_flush_ctrl.sv
// Flush sequencer for the icache: drains refills, sweeps the cleaning module over every set,
// clears all ways' valid bits per index and acks the core. Optional counter: ICACHE_FLUSH_CNT_EN.
module sargantana_icache_flush_ctrl #(
  parameter int ADDR_WIDHT   = 6,
  parameter int ICACHE_DEPTH = 64,
  parameter int NUM_WAYS     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_req_i,
  output logic                  flush_ack_o,
  input  logic                  refill_busy_i,
  output logic                  lookup_stall_o,
  output logic                  busy_o,
  output logic                  clean_en_o,
  input  logic [ADDR_WIDHT-1:0] clean_addr_i,
  input  logic                  clean_done_i,
  output logic [NUM_WAYS-1:0]   vbit_we_o,
  output logic [ADDR_WIDHT-1:0] vbit_addr_o,
  output logic                  vbit_wdata_o,
  output logic [31:0]           flush_cnt_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] SWEEP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic       pending_q, pending_d;
  logic       sweep_active;
  logic       addr_in_range;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d = refill_busy_i ? DRAIN : SWEEP;
        end
      end
      DRAIN: begin
        // Requests while the refill drains are the current flush; only the exit cycle counts as new.
        if (!refill_busy_i) begin
          state_d = SWEEP;
          if (flush_req_i) pending_d = 1'b1;
        end
      end
      SWEEP: begin
        if (flush_req_i) pending_d = 1'b1;
        if (clean_done_i) state_d = DONE;
      end
      DONE: begin
        // A request landing in the ack cycle merges with any pending one into a single extra flush.
        if (pending_q || flush_req_i) begin
          pending_d = 1'b0;
          state_d   = refill_busy_i ? DRAIN : SWEEP;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  assign sweep_active   = (state_q == SWEEP);
  assign addr_in_range  = (32'(clean_addr_i) < ICACHE_DEPTH);
  assign clean_en_o     = sweep_active;
  assign busy_o         = (state_q != IDLE);
  assign lookup_stall_o = (state_q != IDLE);
  assign flush_ack_o    = (state_q == DONE);
  assign vbit_addr_o    = sweep_active ? clean_addr_i : '0;
  assign vbit_wdata_o   = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      assign vbit_we_o[gi] = sweep_active && addr_in_range;
    end
  endgenerate

`ifdef ICACHE_FLUSH_CNT_EN
  logic [31:0] flush_cnt_q, flush_cnt_d;

  assign flush_cnt_d = (state_q == DONE) ? flush_cnt_q + 32'd1 : flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_cnt_q <= 32'd0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign flush_cnt_o = flush_cnt_q;
`else
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_sargantana_icache_flush_ctrl.sv
// Bench for sargantana_icache_flush_ctrl with an emulated cleaning-module address counter
// (ICACHE_DEPTH=8) and a per-cycle behavioural model of the flush sequence.
module tb_sargantana_icache_flush_ctrl;
  localparam int AW    = 6;
  localparam int DEPTH = 8;
  localparam int WAYS  = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_req_i;
  logic            flush_ack_o;
  logic            refill_busy_i;
  logic            lookup_stall_o;
  logic            busy_o;
  logic            clean_en_o;
  logic [AW-1:0]   clean_addr_i;
  logic            clean_done_i;
  logic [WAYS-1:0] vbit_we_o;
  logic [AW-1:0]   vbit_addr_o;
  logic            vbit_wdata_o;
  logic [31:0]     flush_cnt_o;

  always #5 clk_i = ~clk_i;

  sargantana_icache_flush_ctrl #(
    .ADDR_WIDHT(AW), .ICACHE_DEPTH(DEPTH), .NUM_WAYS(WAYS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .refill_busy_i(refill_busy_i), .lookup_stall_o(lookup_stall_o), .busy_o(busy_o),
    .clean_en_o(clean_en_o), .clean_addr_i(clean_addr_i), .clean_done_i(clean_done_i),
    .vbit_we_o(vbit_we_o), .vbit_addr_o(vbit_addr_o), .vbit_wdata_o(vbit_wdata_o),
    .flush_cnt_o(flush_cnt_o)
  );

  // Cleaning-module stand-in: counts while enabled, wraps to 0 after the last set.
  logic spur_done;
  logic emu_last;
  assign emu_last     = (clean_addr_i == AW'(DEPTH - 1));
  assign clean_done_i = emu_last | spur_done;
  always_ff @(posedge clk_i) begin
    if (rst_i) clean_addr_i <= '0;
    else if (clean_en_o) clean_addr_i <= emu_last ? '0 : clean_addr_i + 1'b1;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acks = 0;
  int last_ack = -1;

  // Behavioural model: writes left in the current sweep, next index, refill wait, ack due, extra flush owed.
  int m_left, m_idx, m_cnt;
  bit m_wait, m_ack, m_extra;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic start_flush(input bit rb);
    if (rb) m_wait = 1'b1;
    else begin m_left = DEPTH; m_idx = 0; end
  endtask

  task automatic step(input bit req, input bit rb, input bit rst);
    bit sweeping;
    bit stall;
    int exp_cnt;
    sweeping = (m_left > 0);
    stall = sweeping || m_wait || m_ack;
    flush_req_i   = req;
    refill_busy_i = rb;
    rst_i         = rst;
    spur_done     = !sweeping && ($urandom_range(0, 3) == 0);
    #1;
`ifdef ICACHE_FLUSH_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk("ack",   32'(flush_ack_o),    32'(m_ack));
    chk("busy",  32'(busy_o),         32'(stall));
    chk("stall", 32'(lookup_stall_o), 32'(stall));
    chk("en",    32'(clean_en_o),     32'(sweeping));
    chk("we",    32'(vbit_we_o),      sweeping ? 32'hF : 32'h0);
    chk("addr",  32'(vbit_addr_o),    sweeping ? 32'(m_idx) : 32'h0);
    chk("wdata", 32'(vbit_wdata_o),   32'h0);
    chk("cnt",   flush_cnt_o,         32'(exp_cnt));
    if (flush_ack_o === 1'b1) begin
      n_acks++;
      last_ack = cyc;
      $display("ack cyc=%0d cnt=%0d", cyc, flush_cnt_o);
    end
    if (rst) begin
      m_left = 0; m_idx = 0; m_wait = 0; m_ack = 0; m_extra = 0; m_cnt = 0;
    end else if (m_ack) begin
      m_ack = 1'b0;
      m_cnt++;
      if (m_extra || req) start_flush(rb);
      m_extra = 1'b0;
    end else if (sweeping) begin
      if (req) m_extra = 1'b1;
      m_idx++;
      m_left--;
      if (m_left == 0) m_ack = 1'b1;
    end else if (m_wait) begin
      if (!rb) begin
        m_wait = 1'b0;
        start_flush(1'b0);
        if (req) m_extra = 1'b1;
      end
    end else if (req) begin
      start_flush(rb);
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) step(1'b0, 1'b0, 1'b0);
  endtask

  int t0;
  int acks0;
  bit rb_r;

  initial begin
    rst_i = 1'b1; flush_req_i = 1'b0; refill_busy_i = 1'b0; spur_done = 1'b0;
    m_left = 0; m_idx = 0; m_wait = 0; m_ack = 0; m_extra = 0; m_cnt = 0;
    repeat (3) @(posedge clk_i);
    #1;
    cyc = 0;

    // Basic flush: request at 10, writes 11..18, ack at 19, idle at 20.
    idle_until(10);
    step(1'b1, 1'b0, 1'b0);
    idle_until(22);
    chk("basic_ack_cyc", 32'(last_ack), 32'd19);

    // Drain: refill busy through 3 cycles after request, ack 13 cycles after request.
    idle_until(30);
    t0 = cyc;
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    idle_until(t0 + 16);
    chk("drain_ack_cyc", 32'(last_ack), 32'(t0 + 13));

    // Coalescing: two extra pulses inside the sweep give exactly one extra flush.
    t0 = cyc; acks0 = n_acks;
    step(1'b1, 1'b0, 1'b0);
    idle_until(t0 + 3);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle_until(t0 + 25);
    chk("coalesce_acks", 32'(n_acks - acks0), 32'd2);
    chk("coalesce_2nd_ack", 32'(last_ack), 32'(t0 + 18));

    // Reset on the 4th sweep cycle: no ack, then a clean flush from index 0.
    t0 = cyc; acks0 = n_acks;
    step(1'b1, 1'b0, 1'b0);
    idle_until(t0 + 4);
    step(1'b0, 1'b0, 1'b1);
    idle_until(t0 + 15);
    chk("rst_no_ack", 32'(n_acks - acks0), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    idle_until(t0 + 27);
    chk("rst_reflush_acks", 32'(n_acks - acks0), 32'd1);

    // Request held high: back-to-back sweeps with one ack cycle between them.
    t0 = cyc; acks0 = n_acks;
    repeat (30) step(1'b1, 1'b0, 1'b0);
    idle_until(t0 + 60);
    chk("held_acks", 32'(n_acks - acks0), 32'd5);

    // Randomized traffic with bursty refills and rare resets.
    rb_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) rb_r = ~rb_r;
      step($urandom_range(0, 7) == 0, rb_r, $urandom_range(0, 299) == 0);
    end

    // Three flushes from reset for the counter.
    step(1'b0, 1'b0, 1'b1);
    t0 = cyc; acks0 = n_acks;
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0);
      repeat (11) step(1'b0, 1'b0, 1'b0);
    end
    chk("three_acks", 32'(n_acks - acks0), 32'd3);
`ifdef ICACHE_FLUSH_CNT_EN
    chk("cnt_final", flush_cnt_o, 32'd3);
`else
    chk("cnt_final", flush_cnt_o, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
